// File: rtl/tc08_pkg.sv
// Shared widths, read-channel payload and pair decode for the TC08 read front end.
package tc08_pkg;

   localparam int unsigned LINES_PER_WORD = 4;
   localparam int unsigned MARK_W         = 6;
   localparam int unsigned WORD_W         = 12;
   localparam int unsigned LINE_W         = 3;
   localparam int unsigned SHIFT_W        = WORD_W - LINE_W;
   localparam int unsigned CNT_W          = $clog2(LINES_PER_WORD);

   typedef struct packed {
      logic active;
      logic value;
      logic illegal;
   } rd_chan_t;

   // Differential read-head pair: (1,0)/(0,1) carry a bit, (0,0) is below threshold, (1,1) is a head fault.
   function automatic rd_chan_t decode_pair(input logic pos, input logic neg);
      rd_chan_t c;
      c.active  = pos ^ neg;
      c.value   = pos;
      c.illegal = pos & neg;
      return c;
   endfunction

endpackage

// File: rtl/tc08_diff_rx.sv
// One read-head pair: input capture (2-flop synchronizer when TC08_RD_SYNC_EN is defined),
// decode, and optional rising-edge detect on the positive leg.
module tc08_diff_rx
   import tc08_pkg::*;
#(
   parameter bit EDGE_DET = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     pos,
   input  logic     neg,
   output rd_chan_t chan_c,
   output logic     rise_c
);

   logic pos_s;
   logic neg_s;

`ifdef TC08_RD_SYNC_EN
   logic [1:0] pos_sync;
   logic [1:0] neg_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_sync <= '0;
         neg_sync <= '0;
      end else begin
         pos_sync <= {pos_sync[0], pos};
         neg_sync <= {neg_sync[0], neg};
      end
   end

   assign pos_s = pos_sync[1];
   assign neg_s = neg_sync[1];
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_s <= 1'b0;
         neg_s <= 1'b0;
      end else begin
         pos_s <= pos;
         neg_s <= neg;
      end
   end
`endif

   always_comb chan_c = decode_pair(pos_s, neg_s);

   generate
      if (EDGE_DET) begin : g_edge
         logic pos_prev;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) pos_prev <= 1'b0;
            else     pos_prev <= pos_s;
         end

         // A rise only counts while the pair is driven, so noise out of the idle state is ignored.
         assign rise_c = pos_s & ~pos_prev & chan_c.active;
      end else begin : g_no_edge
         assign rise_c = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/tc08_read_frontend.sv
// TC08 DECtape read front end: line detect, mark window, 12-bit word assembly, stall and head-error status.
// Optional macro TC08_RD_SYNC_EN adds a 2-flop synchronizer per head input (strobe latency 3 instead of 2).
module tc08_read_frontend
   import tc08_pkg::*;
#(
   parameter int unsigned STALL_CYCLES = 16384,
   parameter int unsigned STALL_W      = $clog2(STALL_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              t_trk_rd_pos,
   input  logic              t_trk_rd_neg,
   input  logic              rdmk_rd_pos,
   input  logic              rdmk_rd_neg,
   input  logic              rdd_00_rd_pos,
   input  logic              rdd_00_rd_neg,
   input  logic              rdd_01_rd_pos,
   input  logic              rdd_01_rd_neg,
   input  logic              rdd_02_rd_pos,
   input  logic              rdd_02_rd_neg,
   input  logic              word_clr,
   input  logic              err_clr,
   output logic              line_strobe,
   output logic [LINE_W-1:0] line_data,
   output logic              line_mark,
   output logic [MARK_W-1:0] mark_window,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   output logic              tape_moving,
   output logic              tape_stalled,
   output logic              head_err
);

   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
   localparam logic [CNT_W-1:0]   LAST_LINE = CNT_W'(LINES_PER_WORD - 1);

   rd_chan_t t_ch;
   rd_chan_t mk_ch;
   rd_chan_t d0_ch;
   rd_chan_t d1_ch;
   rd_chan_t d2_ch;
   logic     line_edge_c;
   logic     mk_rise_c;
   logic     d0_rise_c;
   logic     d1_rise_c;
   logic     d2_rise_c;

   tc08_diff_rx #(.EDGE_DET(1'b1)) u_rx_t (
      .clk(clk), .rst(rst), .pos(t_trk_rd_pos), .neg(t_trk_rd_neg), .chan_c(t_ch), .rise_c(line_edge_c)
   );
   tc08_diff_rx #(.EDGE_DET(1'b0)) u_rx_mk (
      .clk(clk), .rst(rst), .pos(rdmk_rd_pos), .neg(rdmk_rd_neg), .chan_c(mk_ch), .rise_c(mk_rise_c)
   );
   tc08_diff_rx #(.EDGE_DET(1'b0)) u_rx_d0 (
      .clk(clk), .rst(rst), .pos(rdd_00_rd_pos), .neg(rdd_00_rd_neg), .chan_c(d0_ch), .rise_c(d0_rise_c)
   );
   tc08_diff_rx #(.EDGE_DET(1'b0)) u_rx_d1 (
      .clk(clk), .rst(rst), .pos(rdd_01_rd_pos), .neg(rdd_01_rd_neg), .chan_c(d1_ch), .rise_c(d1_rise_c)
   );
   tc08_diff_rx #(.EDGE_DET(1'b0)) u_rx_d2 (
      .clk(clk), .rst(rst), .pos(rdd_02_rd_pos), .neg(rdd_02_rd_neg), .chan_c(d2_ch), .rise_c(d2_rise_c)
   );

   // Only the timing pair qualifies lines; activity of the other pairs is not consumed.
   logic unused_chan_c;
   assign unused_chan_c = &{1'b0, mk_ch.active, d0_ch.active, d1_ch.active, d2_ch.active,
                            mk_rise_c, d0_rise_c, d1_rise_c, d2_rise_c};

   logic [LINE_W-1:0] line_val_c;
   logic              any_illegal_c;

   assign line_val_c    = {d0_ch.value, d1_ch.value, d2_ch.value};
   assign any_illegal_c = |{t_ch.illegal, mk_ch.illegal, d0_ch.illegal, d1_ch.illegal, d2_ch.illegal};

   logic [SHIFT_W-1:0] word_shift;
   logic [CNT_W-1:0]   line_cnt;
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_cnt_d;

   // Stall counter restarts on each line and saturates at the threshold.
   always_comb begin
      stall_cnt_d = stall_cnt;
      if (line_edge_c)                  stall_cnt_d = '0;
      else if (stall_cnt != STALL_MAX)  stall_cnt_d = stall_cnt + STALL_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_strobe <= 1'b0;
         line_data   <= '0;
         line_mark   <= 1'b0;
         mark_window <= '0;
      end else begin
         line_strobe <= line_edge_c;
         if (line_edge_c) begin
            line_data   <= line_val_c;
            line_mark   <= mk_ch.value;
            mark_window <= {mark_window[MARK_W-2:0], mk_ch.value};
         end
      end
   end

   // Word framing; a coincident word_clr restarts framing with the current line as the first one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_shift <= '0;
         line_cnt   <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (word_clr) begin
            line_cnt   <= line_edge_c ? CNT_W'(1) : '0;
            word_shift <= line_edge_c ? SHIFT_W'(line_val_c) : '0;
         end else if (line_edge_c) begin
            line_cnt   <= line_cnt + CNT_W'(1);
            word_shift <= {word_shift[SHIFT_W-LINE_W-1:0], line_val_c};
            if (line_cnt == LAST_LINE) begin
               word_data  <= {word_shift, line_val_c};
               word_valid <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt    <= '0;
         tape_stalled <= 1'b0;
         tape_moving  <= 1'b0;
         head_err     <= 1'b0;
      end else begin
         stall_cnt    <= stall_cnt_d;
         tape_stalled <= (stall_cnt_d == STALL_MAX);
         tape_moving  <= t_ch.active;
         if (any_illegal_c)  head_err <= 1'b1;
         else if (err_clr)   head_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tc08_read_frontend.sv
// Directed bench for tc08_read_frontend; expected latency follows TC08_RD_SYNC_EN.
module tb_tc08_read_frontend;

   localparam int unsigned STALL = 40;
`ifdef TC08_RD_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        t_pos, t_neg, mk_pos, mk_neg;
   logic        d0_pos, d0_neg, d1_pos, d1_neg, d2_pos, d2_neg;
   logic        word_clr, err_clr;
   logic        line_strobe;
   logic [2:0]  line_data;
   logic        line_mark;
   logic [5:0]  mark_window;
   logic [11:0] word_data;
   logic        word_valid, tape_moving, tape_stalled, head_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_stb = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tc08_read_frontend #(.STALL_CYCLES(STALL)) dut (
      .clk(clk), .rst(rst),
      .t_trk_rd_pos(t_pos), .t_trk_rd_neg(t_neg),
      .rdmk_rd_pos(mk_pos), .rdmk_rd_neg(mk_neg),
      .rdd_00_rd_pos(d0_pos), .rdd_00_rd_neg(d0_neg),
      .rdd_01_rd_pos(d1_pos), .rdd_01_rd_neg(d1_neg),
      .rdd_02_rd_pos(d2_pos), .rdd_02_rd_neg(d2_neg),
      .word_clr(word_clr), .err_clr(err_clr),
      .line_strobe(line_strobe), .line_data(line_data), .line_mark(line_mark),
      .mark_window(mark_window), .word_data(word_data), .word_valid(word_valid),
      .tape_moving(tape_moving), .tape_stalled(tape_stalled), .head_err(head_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 'o%0o expected 'o%0o", tag, got, exp);
      end
   endtask

   task automatic set_data(input logic [2:0] d, input logic m);
      d0_pos = d[2]; d0_neg = ~d[2];
      d1_pos = d[1]; d1_neg = ~d[1];
      d2_pos = d[0]; d2_neg = ~d[0];
      mk_pos = m;    mk_neg = ~m;
   endtask

   // One tape line: timing rises with data/mark, strobe expected exactly LAT clocks later.
   task automatic drive_line(input string tag, input logic [2:0] d, input logic m, input bit clr,
                             input bit exp_wv, input logic [11:0] exp_wd);
      @(negedge clk);
      set_data(d, m);
      t_pos = 1'b1; t_neg = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         if (clr && k == LAT) word_clr = 1'b1;
         @(posedge clk); #1;
         if (k < LAT) begin
            check({tag, "_early"}, 32'(line_strobe), 32'd0);
         end else begin
            last_stb = cyc;
            check({tag, "_stb"},  32'(line_strobe), 32'd1);
            check({tag, "_data"}, 32'(line_data), 32'(d));
            check({tag, "_mark"}, 32'(line_mark), 32'(m));
            check({tag, "_wv"},   32'(word_valid), 32'(exp_wv));
            if (exp_wv) check({tag, "_wd"}, 32'(word_data), 32'(exp_wd));
         end
         @(negedge clk);
         word_clr = 1'b0;
      end
      t_pos = 1'b0; t_neg = 1'b1;
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(line_strobe), 32'd0);
      check({tag, "_wv0"},   32'(word_valid), 32'd0);
      check({tag, "_hold"},  32'(line_data), 32'(d));
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stb"}, 32'(line_strobe), 32'd0);
      check({tag, "_ld"},  32'(line_data), 32'd0);
      check({tag, "_lm"},  32'(line_mark), 32'd0);
      check({tag, "_mw"},  32'(mark_window), 32'd0);
      check({tag, "_wd"},  32'(word_data), 32'd0);
      check({tag, "_wv"},  32'(word_valid), 32'd0);
      check({tag, "_mov"}, 32'(tape_moving), 32'd0);
      check({tag, "_stl"}, 32'(tape_stalled), 32'd0);
      check({tag, "_err"}, 32'(head_err), 32'd0);
   endtask

   task automatic wait_stall(input string tag, input int from);
      for (int n = 0; n < 3 * int'(STALL) && !tape_stalled; n++) begin
         @(posedge clk); #1;
      end
      check(tag, 32'(cyc - from), 32'(STALL));
   endtask

   logic [2:0]  fwd_d [8]  = '{3'o5, 3'o2, 3'o7, 3'o0, 3'o1, 3'o3, 3'o6, 3'o4};
   logic [2:0]  mk_d  [6]  = '{3'o1, 3'o2, 3'o3, 3'o4, 3'o5, 3'o6};
   logic        mk_m  [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [2:0]  clr_d [6]  = '{3'o1, 3'o2, 3'o6, 3'o5, 3'o4, 3'o3};
   logic [2:0]  rst_d [4]  = '{3'o3, 3'o0, 3'o7, 3'o1};
   logic        rst_m [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      rst = 1'b1;
      t_pos = 1'b0; t_neg = 1'b0;
      mk_pos = 1'b0; mk_neg = 1'b0;
      d0_pos = 1'b0; d0_neg = 1'b0;
      d1_pos = 1'b0; d1_neg = 1'b0;
      d2_pos = 1'b0; d2_neg = 1'b0;
      word_clr = 1'b0; err_clr = 1'b0;

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Idle pairs after reset: stall after exactly STALL clocks.
      wait_stall("stall_after_reset", cyc);
      check("stall_rst_moving", 32'(tape_moving), 32'd0);

      @(negedge clk);
      set_data(3'o0, 1'b0);
      t_neg = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 8; i++)
         drive_line($sformatf("fwd%0d", i), fwd_d[i], 1'b1, 1'b0, (i % 4) == 3,
                    (i == 3) ? 12'o5270 : 12'o1364);
      check("fwd_mw", 32'(mark_window), 32'o77);
      check("fwd_moving", 32'(tape_moving), 32'd1);
      check("fwd_unstalled", 32'(tape_stalled), 32'd0);

      for (int i = 0; i < 6; i++)
         drive_line($sformatf("mk%0d", i), mk_d[i], mk_m[i], 1'b0, i == 3, 12'o1234);
      check("mk_mw", 32'(mark_window), 32'o70);

      // Standalone clear drops the 2-line partial word, then a clear coincides with the 3rd line.
      @(negedge clk); word_clr = 1'b1;
      @(negedge clk); word_clr = 1'b0;
      for (int i = 0; i < 6; i++)
         drive_line($sformatf("clr%0d", i), clr_d[i], 1'b0, i == 2, i == 5, 12'o6543);
      check("clr_mw", 32'(mark_window), 32'o00);

      drive_line("stl_line", 3'o0, 1'b0, 1'b0, 1'b0, 12'o0);
      @(negedge clk);
      t_pos = 1'b0; t_neg = 1'b0;
      wait_stall("stall_count", last_stb);
      check("stall_moving", 32'(tape_moving), 32'd0);
      drive_line("unstall", 3'o2, 1'b0, 1'b0, 1'b0, 12'o0);
      check("unstall_stl", 32'(tape_stalled), 32'd0);
      check("unstall_moving", 32'(tape_moving), 32'd1);

      // One-cycle illegal pair on rdd_01 sets a sticky error.
      @(negedge clk); d1_pos = 1'b1; d1_neg = 1'b1;
      @(negedge clk); set_data(3'o2, 1'b0);
      repeat (LAT + 1) @(posedge clk);
      #1 check("err_set", 32'(head_err), 32'd1);
      repeat (5) @(posedge clk);
      #1 check("err_held", 32'(head_err), 32'd1);
      @(negedge clk); err_clr = 1'b1;
      @(posedge clk); #1 check("err_clr", 32'(head_err), 32'd0);
      @(negedge clk); err_clr = 1'b0;
      d1_pos = 1'b1; d1_neg = 1'b1;
      repeat (LAT + 1) @(posedge clk);
      #1 check("err_set2", 32'(head_err), 32'd1);
      @(negedge clk); err_clr = 1'b1;
      @(posedge clk); #1 check("err_set_wins", 32'(head_err), 32'd1);
      @(negedge clk); err_clr = 1'b0;
      set_data(3'o2, 1'b0);
      repeat (LAT + 2) @(posedge clk);
      #1 check("err_sticky", 32'(head_err), 32'd1);

      // Reset mid-word after two lines.
      @(negedge clk); word_clr = 1'b1;
      @(negedge clk); word_clr = 1'b0;
      drive_line("pre0", 3'o7, 1'b1, 1'b0, 1'b0, 12'o0);
      drive_line("pre1", 3'o5, 1'b1, 1'b0, 1'b0, 12'o0);
      #3 rst = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++)
         drive_line($sformatf("post%0d", i), rst_d[i], rst_m[i], 1'b0, i == 3, 12'o3071);
      check("post_mw", 32'(mark_window), 32'o05);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
